vga_rx: RTL and testbench

VGA_RX -- requirements
Module: vga_rx

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_sync_edge.sv | 30 +++
 rtl/vga_rx.sv | 175 +++++++++++++++++
 tb/tb_vga_rx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants, lock FSM state encoding and a saturating counter helper.
package vga_pkg;

  localparam int H_ACT_DEF = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_ACT_DEF + H_FP + H_SYNC + H_BP;

  localparam int V_ACT_DEF = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_ACT_DEF + V_FP + V_SYNC + V_BP;

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_CHECK    = 2'd1,
    S_LOCKED   = 2'd2
  } state_e;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Two-stage sampler for one sync/blank input with rise and fall pulses.
module vga_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o    = s1_q;
  assign rise_o = s1_q & ~s2_q;
  assign fall_o = ~s1_q & s2_q;

endmodule

// File: rtl/vga_rx.sv
// VGA receiver: pixel/line counting, registered pixel output, timing lock
// detection and HS period measurement.
module vga_rx
  import vga_pkg::*;
#(
  parameter int H_ACT       = H_ACT_DEF,
  parameter int V_ACT       = V_ACT_DEF,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        i_clk_25M,
  input  logic        i_rst_n,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_blank_n,
  input  logic [7:0]  i_r,
  input  logic [7:0]  i_g,
  input  logic [7:0]  i_b,
  output logic        o_pix_valid,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic        o_sof,
  output logic        o_eol,
  output logic        o_locked,
  output logic        o_err,
  output logic [10:0] o_h_total
);

  localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  logic hs_lvl_w, hs_rise_w, hs_fall_w;
  logic vs_lvl_w, vs_rise_w, vs_fall_w;
  logic bl_w, bl_rise_w, bl_fall_w;
  logic unused_edges_w;

  vga_sync_edge #(.RST_VAL(1'b1)) u_hs (
    .clk_i(i_clk_25M), .rst_ni(i_rst_n), .d_i(i_hs),
    .q_o(hs_lvl_w), .rise_o(hs_rise_w), .fall_o(hs_fall_w)
  );
  vga_sync_edge #(.RST_VAL(1'b1)) u_vs (
    .clk_i(i_clk_25M), .rst_ni(i_rst_n), .d_i(i_vs),
    .q_o(vs_lvl_w), .rise_o(vs_rise_w), .fall_o(vs_fall_w)
  );
  vga_sync_edge #(.RST_VAL(1'b0)) u_blank (
    .clk_i(i_clk_25M), .rst_ni(i_rst_n), .d_i(i_blank_n),
    .q_o(bl_w), .rise_o(bl_rise_w), .fall_o(bl_fall_w)
  );

  assign unused_edges_w = ^{hs_lvl_w, hs_rise_w, vs_lvl_w, vs_rise_w, bl_rise_w};

  logic [7:0]  r_s_q, g_s_q, b_s_q;
  logic [9:0]  pix_q, pix_d, line_q, line_d;
  logic [9:0]  x_cur_w, y_cur_w;
  logic [10:0] h_cnt_q, h_cnt_d, h_total_q;
  logic        frame_bad_q, frame_bad_d;
  logic        line_bad_w, frame_bad_w;

  logic        valid_q, sof_q, eol_q;
  logic [7:0]  r_q, g_q, b_q;
  logic [9:0]  x_q, y_q;

  state_e          state_q;
  logic [GW-1:0]   good_q;
  logic            locked_q, err_q;

  // Sync falls clear the counters in the same cycle they are used for output.
  assign x_cur_w = hs_fall_w ? 10'd0 : pix_q;
  assign y_cur_w = vs_fall_w ? 10'd0 : line_q;
  assign pix_d   = bl_w      ? sat_inc10(x_cur_w) : x_cur_w;
  assign line_d  = bl_fall_w ? sat_inc10(y_cur_w) : y_cur_w;
  assign h_cnt_d = hs_fall_w ? 11'd1
                 : ((h_cnt_q == 11'h7FF) ? h_cnt_q : h_cnt_q + 11'd1);

  assign line_bad_w  = (bl_fall_w && (x_cur_w != 10'(H_ACT)))
                     || (bl_w && (x_cur_w == 10'(H_ACT)));
  assign frame_bad_w = frame_bad_q | line_bad_w | (line_q != 10'(V_ACT));
  assign frame_bad_d = vs_fall_w ? 1'b0 : (frame_bad_q | line_bad_w);

  always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s_q       <= '0;
      g_s_q       <= '0;
      b_s_q       <= '0;
      pix_q       <= '0;
      line_q      <= '0;
      h_cnt_q     <= '0;
      h_total_q   <= '0;
      frame_bad_q <= 1'b0;
      valid_q     <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
    end else begin
      r_s_q       <= i_r;
      g_s_q       <= i_g;
      b_s_q       <= i_b;
      pix_q       <= pix_d;
      line_q      <= line_d;
      h_cnt_q     <= h_cnt_d;
      if (hs_fall_w) h_total_q <= h_cnt_q;
      frame_bad_q <= frame_bad_d;
      valid_q     <= bl_w;
      r_q         <= bl_w ? r_s_q : 8'd0;
      g_q         <= bl_w ? g_s_q : 8'd0;
      b_q         <= bl_w ? b_s_q : 8'd0;
      x_q         <= x_cur_w;
      y_q         <= y_cur_w;
      sof_q       <= bl_w && (x_cur_w == 10'd0) && (y_cur_w == 10'd0);
      eol_q       <= bl_w && (x_cur_w == 10'(H_ACT - 1));
    end
  end

  // The partial frame seen before the first VS fall is never judged.
  always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_UNLOCKED;
      good_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_UNLOCKED: begin
          if (vs_fall_w) begin
            state_q <= S_CHECK;
            good_q  <= '0;
          end
        end
        S_CHECK: begin
          if (vs_fall_w) begin
            if (frame_bad_w) begin
              good_q <= '0;
            end else if (good_q == GW'(LOCK_FRAMES - 1)) begin
              state_q  <= S_LOCKED;
              locked_q <= 1'b1;
              good_q   <= '0;
            end else begin
              good_q <= good_q + 1'b1;
            end
          end
        end
        S_LOCKED: begin
          if (line_bad_w || (vs_fall_w && frame_bad_w)) begin
            state_q  <= S_UNLOCKED;
            locked_q <= 1'b0;
            err_q    <= 1'b1;
          end
        end
        default: begin
          state_q  <= S_UNLOCKED;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_pix_valid = valid_q;
  assign o_r         = r_q;
  assign o_g         = g_q;
  assign o_b         = b_q;
  assign o_x         = x_q;
  assign o_y         = y_q;
  assign o_sof       = sof_q;
  assign o_eol       = eol_q;
  assign o_locked    = locked_q;
  assign o_err       = err_q;
  assign o_h_total   = h_total_q;

endmodule

// File: tb/tb_vga_rx.sv
// Randomized bench for vga_rx on a reduced timing grid, checked cycle by cycle
// against a behavioural model of the receiver's rules.
module tb_vga_rx;

  localparam int HA = 32, HFP = 4, HSY = 8, HBP = 4, HT = HA + HFP + HSY + HBP;
  localparam int VA = 10, VFP = 2, VSY = 2, VBP = 2, VT = VA + VFP + VSY + VBP;
  localparam int LOCKF = 2;
  localparam int VS_START = (VA + VFP) * HT + HA + HFP;
  localparam int VS_END   = VS_START + VSY * HT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hs = 1'b1, vs = 1'b1, bl = 1'b0;
  logic [7:0] ri = '0, gi = '0, bi = '0;

  logic        o_pix_valid, o_sof, o_eol, o_locked, o_err;
  logic [7:0]  o_r, o_g, o_b;
  logic [9:0]  o_x, o_y;
  logic [10:0] o_h_total;

  vga_rx #(.H_ACT(HA), .V_ACT(VA), .LOCK_FRAMES(LOCKF)) dut (
    .i_clk_25M(clk), .i_rst_n(rst_n), .i_hs(hs), .i_vs(vs), .i_blank_n(bl),
    .i_r(ri), .i_g(gi), .i_b(bi),
    .o_pix_valid(o_pix_valid), .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .o_x(o_x), .o_y(o_y), .o_sof(o_sof), .o_eol(o_eol),
    .o_locked(o_locked), .o_err(o_err), .o_h_total(o_h_total)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] r, g, b;
    int         x, y;
    logic       sof, eol, lk, err;
    int         ht;
    bit         htk;
  } exp_t;

  exp_t e1, e2, zero_e;

  int n_checks = 0, n_errors = 0, err_pulses = 0;

  // behavioural model state
  int px, ln, t, last_hf, good, mht;
  bit p_hs, p_vs, p_bl, fbad, armed, mlocked, mhtk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    px = 0; ln = 0; t = 0; last_hf = -1; good = 0; mht = 0;
    p_hs = 1; p_vs = 1; p_bl = 0; fbad = 0; armed = 0; mlocked = 0; mhtk = 0;
  endtask

  task automatic step(input logic h, input logic v, input logic b,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] bb,
                      input logic rst);
    exp_t e;
    bit hf, vf, bf, lbad, fr_bad, was_run;
    int xc, yc;
    @(negedge clk);
    check_eq("pix_valid", o_pix_valid, e2.v);
    check_eq("r", o_r, e2.r);
    check_eq("g", o_g, e2.g);
    check_eq("b", o_b, e2.b);
    if (e2.v) begin
      check_eq("x", o_x, e2.x);
      check_eq("y", o_y, e2.y);
    end
    check_eq("sof", o_sof, e2.sof);
    check_eq("eol", o_eol, e2.eol);
    check_eq("locked", o_locked, e2.lk);
    check_eq("err", o_err, e2.err);
    if (e2.htk) check_eq("h_total", o_h_total, e2.ht);
    if (o_err === 1'b1) err_pulses++;

    was_run = rst_n;
    rst_n = rst; hs = h; vs = v; bl = b; ri = r; gi = g; bi = bb;
    if (!rst) begin
      model_reset();
      e1 = zero_e;
      e2 = zero_e;
      if (was_run) begin
        #1;
        check_eq("async_locked", o_locked, 0);
        check_eq("async_valid", o_pix_valid, 0);
      end
      return;
    end

    t++;
    hf = p_hs && !h;
    vf = p_vs && !v;
    bf = p_bl && !b;
    if (hf) begin
      if (last_hf >= 0) begin
        mht  = (t - last_hf > 2047) ? 2047 : t - last_hf;
        mhtk = 1;
      end
      last_hf = t;
    end
    xc = hf ? 0 : px;
    yc = vf ? 0 : ln;
    lbad = (bf && xc != HA) || (b && xc == HA);
    e.err = 0;
    if (mlocked && lbad) begin
      e.err = 1; mlocked = 0;
    end else if (vf) begin
      fr_bad = fbad || lbad || (ln != VA);
      if (mlocked) begin
        if (fr_bad) begin e.err = 1; mlocked = 0; end
      end else if (!armed) begin
        armed = 1; good = 0;
      end else if (fr_bad) begin
        good = 0;
      end else begin
        good++;
        if (good == LOCKF) begin mlocked = 1; armed = 0; end
      end
    end
    fbad = vf ? 0 : (fbad || lbad);
    px = b ? ((xc + 1 > 1023) ? 1023 : xc + 1) : xc;
    ln = bf ? ((yc + 1 > 1023) ? 1023 : yc + 1) : yc;
    p_hs = h; p_vs = v; p_bl = b;

    e.v   = b;
    e.r   = b ? r : 8'd0;
    e.g   = b ? g : 8'd0;
    e.b   = b ? bb : 8'd0;
    e.x   = xc;
    e.y   = yc;
    e.sof = b && xc == 0 && yc == 0;
    e.eol = b && xc == HA - 1;
    e.lk  = mlocked;
    e.ht  = mht;
    e.htk = mhtk;
    e2 = e1;
    e1 = e;
  endtask

  // short_line: line with one pixel missing; n_act: active lines; rst_line: reset pulse line
  task automatic frame(input int short_line, input int n_act, input int rst_line);
    logic h, v, b, rs;
    logic [7:0] ramp;
    int pos;
    for (int l = 0; l < VT; l++) begin
      for (int c = 0; c < HT; c++) begin
        pos  = l * HT + c;
        b    = (l < n_act) && (c < ((l == short_line) ? HA - 1 : HA));
        h    = !(c >= HA + HFP && c < HA + HFP + HSY);
        v    = !(pos >= VS_START && pos < VS_END);
        rs   = !(l == rst_line && c >= 10 && c < 14);
        ramp = 8'(c);
        step(h, v, b, b ? ramp : 8'($urandom), 8'($urandom), 8'($urandom), rs);
      end
    end
  endtask

  initial begin
    zero_e = '{v: 1'b0, r: 8'd0, g: 8'd0, b: 8'd0, x: 0, y: 0,
               sof: 1'b0, eol: 1'b0, lk: 1'b0, err: 1'b0, ht: 0, htk: 1'b0};
    e1 = zero_e;
    e2 = zero_e;
    model_reset();
    repeat (4) step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    check_eq("reset_valid", o_pix_valid, 0);
    check_eq("reset_h_total", o_h_total, 0);

    repeat (3) frame(-1, VA, -1);
    check_eq("locked_after_3_frames", o_locked, 1);
    check_eq("h_total_nominal", o_h_total, HT);

    frame($urandom_range(0, VA - 1), VA, -1);
    check_eq("unlocked_after_short_line", o_locked, 0);
    repeat (2) frame(-1, VA, -1);
    check_eq("relock_after_short_line", o_locked, 1);

    frame(-1, VA - 1, -1);
    check_eq("unlocked_after_short_frame", o_locked, 0);
    repeat (3) frame(-1, VA, -1);
    check_eq("relock_after_short_frame", o_locked, 1);

    frame(-1, VA, 5);
    check_eq("unlocked_after_reset", o_locked, 0);
    repeat (2) frame(-1, VA, -1);
    check_eq("relock_after_reset", o_locked, 1);

    repeat (4) step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    check_eq("err_pulse_total", err_pulses, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
